booth_mult_fsm: RTL and testbench

//  Sequential signed radix-2 Booth multiplier.
//  - Consumes init_FSM from the control unit; returns a one-cycle complete pulse to it.
//  - The control unit answers complete by dropping init_FSM and raising permit.
//  - One iteration per clock; result held in a product register until the next completed run.

---
 rtl/mult_pkg.sv | 13 +
 rtl/booth_mult_fsm_step.sv | 32 +++
 rtl/booth_mult_fsm.sv | 114 +++++++++++
 tb/tb_booth_mult_fsm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential radix-2 Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } mult_state_e;

  localparam int DW_DEFAULT = 8;

endpackage

// File: rtl/booth_mult_fsm_step.sv
// One combinational radix-2 Booth iteration: conditional add/subtract of Mr
// into A, then arithmetic right shift of the packed {A, Qr, q_1} register.
module booth_step #(
  parameter int DW = 8
) (
  input  logic [2*DW+1:0] acc_in,
  input  logic [DW:0]     mr,
  output logic [2*DW+1:0] acc_out
);

  logic [DW:0]   a;
  logic [DW-1:0] qr;
  logic          q_1;
  logic [DW:0]   a_sum;

  assign a   = acc_in[2*DW+1 -: DW+1];
  assign qr  = acc_in[DW:1];
  assign q_1 = acc_in[0];

  always_comb begin
    a_sum = a;
    case ({qr[0], q_1})
      2'b01:   a_sum = a + mr;
      2'b10:   a_sum = a - mr;
      default: a_sum = a;
    endcase
  end

  // Sign bit of the accumulator is replicated; old Qr[0] falls into q_1.
  assign acc_out = {a_sum[DW], a_sum, qr};

endmodule

// File: rtl/booth_mult_fsm.sv
// Sequential signed Booth multiplier, one iteration per clock, with a
// four-state run controller and a registered, held product.
module booth_mult_fsm
  import mult_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_FSM,
  input  logic [DW-1:0]     multiplicand,
  input  logic [DW-1:0]     multiplier,
  output logic              complete,
  output logic              busy,
  output logic [2*DW-1:0]   product,
  output mult_state_e       state
);

  // Handshake: init_FSM is a level held by the control unit for the whole run;
  // complete is a single-cycle pulse, after which init_FSM must drop for at
  // least one edge before another run is accepted. Dropping init_FSM while
  // busy aborts the run and leaves product untouched.

  localparam int CW = $clog2(DW + 1);

  logic [DW:0]      a;
  logic [DW-1:0]    qr;
  logic             q_1;
  logic [DW:0]      mr;
  logic [CW-1:0]    count;

  logic [2*DW+1:0]  step_in;
  logic [2*DW+1:0]  step_out;
  logic [DW:0]      next_a;
  logic [DW-1:0]    next_qr;
  logic             next_q1;
  logic             last_step;

  assign step_in = {a, qr, q_1};

  booth_step #(
    .DW (DW)
  ) u_step (
    .acc_in  (step_in),
    .mr      (mr),
    .acc_out (step_out)
  );

  assign next_a    = step_out[2*DW+1 -: DW+1];
  assign next_qr   = step_out[DW:1];
  assign next_q1   = step_out[0];
  assign last_step = (count == CW'(DW - 1));
  assign busy      = (state == CALC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      complete <= 1'b0;
      product  <= '0;
      count    <= '0;
      a        <= '0;
      qr       <= '0;
      q_1      <= 1'b0;
      mr       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (init_FSM) begin
            // One extra accumulator bit keeps -2^(DW-1) exact when negated.
            mr    <= {multiplicand[DW-1], multiplicand};
            a     <= '0;
            qr    <= multiplier;
            q_1   <= 1'b0;
            count <= '0;
            state <= CALC;
          end
        end

        CALC: begin
          if (!init_FSM) begin
            state <= IDLE;
          end else begin
            a     <= next_a;
            qr    <= next_qr;
            q_1   <= next_q1;
            count <= count + CW'(1);
            if (last_step) begin
              product  <= {next_a[DW-1:0], next_qr};
              complete <= 1'b1;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          complete <= 1'b0;
          state    <= HOLD;
        end

        HOLD: begin
          if (!init_FSM) begin
            state <= IDLE;
          end
        end

        default: begin
          complete <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_fsm.sv
// Directed bench for booth_mult_fsm: expected products are queued when a run
// is started and popped when the complete pulse is seen.
module tb_booth_mult_fsm;
  import mult_pkg::*;

  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              init_fsm;
  logic [DW-1:0]     mcand;
  logic [DW-1:0]     mplier;
  logic              complete;
  logic              busy;
  logic [2*DW-1:0]   product;
  mult_state_e       state;

  int passes = 0;
  int total  = 0;
  logic [2*DW-1:0] exp_q[$];

  booth_mult_fsm #(
    .DW (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .init_FSM     (init_fsm),
    .multiplicand (mcand),
    .multiplier   (mplier),
    .complete     (complete),
    .busy         (busy),
    .product      (product),
    .state        (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Driver: start a run, hold init until complete, optionally keep init high
  // afterwards, then release and return to IDLE.
  task automatic run_op(input logic [DW-1:0] m, input logic [DW-1:0] q,
                        input bit scramble, input int hold_after, input string tag);
    int p;
    int cyc;
    int bcnt;
    int extra;
    logic [2*DW-1:0] exp;
    p = int'($signed(m)) * int'($signed(q));
    exp_q.push_back(p[2*DW-1:0]);
    mcand    = m;
    mplier   = q;
    init_fsm = 1'b1;
    tick();
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    cyc  = 0;
    bcnt = 0;
    while (!complete && cyc < 4 * DW) begin
      if (busy) bcnt++;
      if (scramble) begin
        mcand  = DW'($urandom_range(0, 255));
        mplier = DW'($urandom_range(0, 255));
      end
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(DW));
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'(DW));
    exp = exp_q.pop_front();
    check({tag, "_product"}, 32'(product), 32'(exp));
    extra = 0;
    for (int i = 0; i < hold_after; i++) begin
      tick();
      if (complete) extra++;
    end
    if (hold_after > 0) begin
      check({tag, "_extra_complete"}, 32'(extra), 32'd0);
      check({tag, "_hold_state"}, 32'(state), 32'(HOLD));
      check({tag, "_hold_busy"}, 32'(busy), 32'd0);
    end
    init_fsm = 1'b0;
    tick();
    check({tag, "_complete_drop"}, 32'(complete), 32'd0);
    tick();
    check({tag, "_idle"}, 32'(state), 32'(IDLE));
    check({tag, "_product_held"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int ncomp;
    rst      = 1'b1;
    init_fsm = 1'b0;
    mcand    = '0;
    mplier   = '0;
    repeat (3) tick();
    check("reset_complete", 32'(complete), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_state", 32'(state), 32'(IDLE));

    // T1; init is already high when rst falls, so the first edge starts the run
    init_fsm = 1'b1;
    mcand    = 8'd3;
    mplier   = 8'd5;
    rst      = 1'b0;
    run_op(8'd3, 8'd5, 1'b0, 0, "t1");
    check("t1_const", 32'(product), 32'h000F);

    // T2, second run with operands scrambled during CALC
    run_op(8'hF9, 8'd6, 1'b0, 0, "t2a");
    check("t2a_const", 32'(product), 32'hFFD6);
    run_op(8'd6, 8'hF9, 1'b1, 0, "t2b");
    check("t2b_const", 32'(product), 32'hFFD6);

    // T3 extremes
    run_op(8'h80, 8'h80, 1'b0, 0, "t3a");
    check("t3a_const", 32'(product), 32'h4000);
    run_op(8'h80, 8'h7F, 1'b0, 0, "t3b");
    check("t3b_const", 32'(product), 32'hC080);

    // Random operand pairs against the integer model
    for (int i = 0; i < 4; i++) begin
      run_op(DW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)), 1'b0, 0, "rnd");
    end

    // T4: async reset between edges in the middle of CALC
    mcand    = 8'd5;
    mplier   = 8'd5;
    init_fsm = 1'b1;
    tick();
    repeat (3) tick();
    check("t4_busy_before", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_complete", 32'(complete), 32'd0);
    check("t4_product", 32'(product), 32'd0);
    check("t4_state", 32'(state), 32'(IDLE));
    init_fsm = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // T5: abort at cycle 4 of CALC leaves the previous product
    run_op(8'd3, 8'd5, 1'b0, 0, "t5_pre");
    mcand    = 8'd9;
    mplier   = 8'd9;
    init_fsm = 1'b1;
    tick();
    repeat (3) tick();
    init_fsm = 1'b0;
    tick();
    check("t5_abort_state", 32'(state), 32'(IDLE));
    ncomp = 0;
    for (int i = 0; i < DW + 4; i++) begin
      if (complete) ncomp++;
      tick();
    end
    check("t5_no_complete", 32'(ncomp), 32'd0);
    check("t5_product", 32'(product), 32'h000F);

    // T6: init held high after complete, then a fresh run after it drops
    run_op(8'd11, 8'hFD, 1'b0, 5, "t6a");
    run_op(8'd2, 8'hFD, 1'b0, 0, "t6b");
    check("t6b_const", 32'(product), 32'hFFFA);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
